// File: rtl/quiz_judge_pkg.sv
// Shared quiz-game types and default sizes used by the judge, question generator
// and display blocks.
package quiz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam int DEF_WIDTH     = 7;
  localparam int DEF_MAX_LIVES = 3;
  localparam int DEF_SCORE_W   = 8;

endpackage

// File: rtl/quiz_judge_answer_timer.sv
// Answer time-limit counter: counts cycles while run is high and flags expiry
// on the cycle the count reaches TIMEOUT_CYCLES-1.
module answer_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear in the expiry cycle (new question) restarts the window instead.
  assign expire = run && !clear && (cnt_q == LAST);

endmodule

// File: rtl/quiz_judge.sv
// Registered answer judge: tracks lives, score and game-over across a game.
// Optional answer time limit is built when ANSWER_TIMEOUT_EN is defined.
module quiz_judge
  import quiz_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int MAX_LIVES      = DEF_MAX_LIVES,
  parameter int LIFE_W         = $clog2(MAX_LIVES + 1),
  parameter int SCORE_W        = DEF_SCORE_W,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               new_ques,
  input  logic [WIDTH-1:0]   result,
  input  logic               kb_valid,
  input  logic [WIDTH-1:0]   kb_result,
  output logic               right,
  output logic               wrong,
  output logic               timeout,
  output logic               awaiting,
  output logic [LIFE_W-1:0]  lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  if (MAX_LIVES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("quiz_judge: MAX_LIVES and TIMEOUT_CYCLES must be at least 1");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               right_q, right_d;
  logic               wrong_q, wrong_d;
  logic               timeout_q, timeout_d;
  logic               awaiting_q, awaiting_d;
  logic               game_over_q, game_over_d;
  logic               expire;

`ifdef ANSWER_TIMEOUT_EN
  answer_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (start || new_ques),
    .run    (state_q == ST_WAIT),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    logic miss;
    logic judged;
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d     = state_q;
    exp_d       = exp_q;
    lives_d     = lives_q;
    score_d     = score_q;
    right_d     = 1'b0;
    wrong_d     = 1'b0;
    timeout_d   = 1'b0;
    game_over_d = game_over_q;
    miss        = 1'b0;
    judged      = 1'b0;

    if (start) begin
      state_d     = ST_HOLD;
      lives_d     = LIFE_W'(MAX_LIVES);
      score_d     = '0;
      game_over_d = 1'b0;
      exp_d       = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (new_ques) begin
            exp_d   = result;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (kb_valid) begin
            judged = 1'b1;
            if (kb_result == exp_q) begin
              right_d = 1'b1;
              if (score_q != '1) score_d = score_q + SCORE_W'(1);
            end else begin
              miss = 1'b1;
            end
          end else if (expire) begin
            judged    = 1'b1;
            miss      = 1'b1;
            timeout_d = 1'b1;
          end

          if (miss) begin
            wrong_d = 1'b1;
            if (lives_q != '0) lives_d = lives_q - LIFE_W'(1);
          end

          // Judging uses the old expected value; a same-cycle question replaces it after.
          if (new_ques) exp_d = result;

          if (miss && lives_q <= LIFE_W'(1)) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
          end else if (judged && !new_ques) begin
            state_d = ST_HOLD;
          end
        end
        default: ;
      endcase
    end

    awaiting_d = (state_d == ST_WAIT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      exp_q       <= '0;
      lives_q     <= '0;
      score_q     <= '0;
      right_q     <= 1'b0;
      wrong_q     <= 1'b0;
      timeout_q   <= 1'b0;
      awaiting_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      right_q     <= right_d;
      wrong_q     <= wrong_d;
      timeout_q   <= timeout_d;
      awaiting_q  <= awaiting_d;
      game_over_q <= game_over_d;
    end
  end

  assign right     = right_q;
  assign wrong     = wrong_q;
  assign timeout   = timeout_q;
  assign awaiting  = awaiting_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign game_over = game_over_q;

endmodule
